multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the LEGv8 datapath (regfile, ALU, data memory, PC) over several
//  cycles per instruction instead of one. It drives every datapath mux/enable and waits on a
//  variable-latency data-memory handshake. It also counts retired instructions and halts on a
//  fault. It replaces the combinational single-cycle control plus the free-running PC update.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles MEM waits for MemReady before faulting (>=1)
//  COUNT_W      32  width of RetireCount
// PORTS
//  CLK          in   1        clock; all state updates on posedge
//  Reset        in   1        synchronous, active-high reset
//  Opcode       in   11       IR[31:21], valid from DECODE onward
//  ALUZero      in   1        ALU zero flag (used in EXEC_CB)
//  MemReady     in   1        data memory done; sampled only in MEM
//  IRWrite      out  1        latch instruction register
//  PCWrite      out  1        load PC this cycle
//  PCSrc        out  1        0 = PC+4, 1 = PC + (SignExtImm64<<2)
//  Reg2Loc      out  1        0 = rm, 1 = rd onto regfile RB
//  ALUSrc       out  1        0 = busB, 1 = SignExtImm64
//  ALUOp        out  2        00 add, 01 pass-B, 10 R-type funct decode
//  MemRead      out  1        data-memory read request (level, held until MemReady)
//  MemWrite     out  1        data-memory write request (level, held until MemReady)
//  MemToReg     out  1        0 = ALU result, 1 = dMemOut onto busW
//  RegWrite     out  1        regfile write enable
//  Halted       out  1        FSM in HALT
//  Fault        out  2        00 none, 01 illegal opcode, 10 memory timeout (sticky)
//  RetireCount  out  COUNT_W  instructions completed since reset
// BEHAVIOUR
//  Reset high: next state FETCH, RetireCount=0, Fault=00, timeout counter=0.
//   All outputs forced 0 while Reset is high, including mid-MEM (request dropped).
//  Outputs are decoded from state only, except PCSrc in EXEC_CB (=ALUZero). Unlisted outputs are 0.
//  FETCH:   IRWrite=1 -> DECODE
//  DECODE:  classify Opcode -> EXEC_R | EXEC_M | EXEC_CB | BR | HALT (Fault=01 if illegal)
//   R: ADD 458, SUB 658, AND 450, ORR 550   M: LDUR 7C2, STUR 7C0
//   CB: CBZ 5A0-5A7                         B: 0A0-0BF
//  EXEC_R:  ALUSrc=0, ALUOp=10 -> WB_R
//  WB_R:    ALUOp=10, RegWrite=1, PCWrite=1, PCSrc=0 -> FETCH
//  EXEC_M:  Reg2Loc=1, ALUSrc=1, ALUOp=00 -> MEM
//  MEM:     Reg2Loc=1, ALUSrc=1, ALUOp=00; MemRead (LDUR) or MemWrite (STUR) held every cycle
//   MemReady=1: LDUR -> WB_M; STUR -> PCWrite=1, PCSrc=0, -> FETCH
//   counter reaches MEM_TIMEOUT without MemReady: -> HALT, Fault=10
//   MemReady in the same cycle as timeout: MemReady wins
//   counter clears on entry to MEM
//  WB_M:    ALUSrc=1, MemToReg=1, RegWrite=1, PCWrite=1, PCSrc=0 -> FETCH
//  EXEC_CB: Reg2Loc=1, ALUOp=01, PCWrite=1, PCSrc=ALUZero -> FETCH
//  BR:      PCWrite=1, PCSrc=1 -> FETCH
//  HALT:    Halted=1, all enables 0; stays until Reset; Fault holds its value
//  RetireCount increments by 1 on every cycle with PCWrite=1; wraps modulo 2^COUNT_W
//  Latency (cycles, FETCH to next FETCH): R=4, LDUR=5+W, STUR=4+W, CBZ=3, B=3
//   W = cycles MemReady is low in MEM
//  State register: 4-bit binary; unused encodings -> HALT with Fault=01
// STRUCTURE
//  Shared include multicycle_defs.vh:
//   state encodings, opcode constants/masks, ALUOp codes, Fault codes
//  Sub-module opcode_classifier: Opcode -> {isR, isMem, isLoad, isCB, isB, illegal}
//   Combinational; reused by a future pipelined control unit
//  Top level holds: state register, next-state logic, output decode, timeout counter, retire counter
// TESTING
//  ADD (458) with MemReady ignored
//   -> states F,D,ER,WBR; RegWrite and PCWrite only in cycle 4; RetireCount 0->1
//  LDUR (7C2), MemReady low 3 cycles then high
//   -> MemRead high exactly 4 cycles; MemToReg=RegWrite=1 in the next cycle; total 8 cycles
//  CBZ (5A4) with ALUZero=1, then ALUZero=0
//   -> PCSrc=1, then PCSrc=0; PCWrite=1 both times in cycle 3
//  STUR (7C0), MemReady never asserted, MEM_TIMEOUT=16
//   -> MemWrite high 16 cycles, then Halted=1, Fault=10; stays there until Reset
//  Opcode 7FF -> HALT, Fault=01; Reset pulse -> FETCH, Fault=00, RetireCount=0
//  Reset asserted in MEM -> MemRead=0 in the same cycle; FETCH follows; MemReady=1 in the reset cycle has no effect

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle LEGv8 control unit.
//   state_t     : 4-bit binary state encoding (values 10..15 unused)
//   OP_*        : opcode constants and prefix fields used by the classifier
//   ALUOP_*     : ALUOp codes driven onto the ALU control
//   FAULT_*     : Fault output codes
//   op_class_t  : classifier result bundle
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_WB_R    = 4'd3,
        ST_EXEC_M  = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB_M    = 4'd6,
        ST_EXEC_CB = 4'd7,
        ST_BR      = 4'd8,
        ST_HALT    = 4'd9
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    // CBZ occupies 5A0-5A7: compare Opcode[10:3]
    localparam logic [7:0]  OP_CBZ_PFX = 8'hB4;
    // B occupies 0A0-0BF: compare Opcode[10:5]
    localparam logic [5:0]  OP_B_PFX   = 6'h05;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASS_B = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_MEM_TMO = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_mem;
        logic is_load;
        logic is_cb;
        logic is_b;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// opcode_classifier: purely combinational decode of IR[31:21] into
// instruction classes. Kept separate so a pipelined control unit can reuse it.
//   opcode : in  11  IR[31:21]
//   cls    : out     {is_r, is_mem, is_load, is_cb, is_b, illegal}
module opcode_classifier
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   cls
);

    always_comb begin
        cls         = '0;
        cls.is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_ORR);
        cls.is_load = (opcode == OP_LDUR);
        cls.is_mem  = (opcode == OP_LDUR) || (opcode == OP_STUR);
        cls.is_cb   = (opcode[10:3] == OP_CBZ_PFX);
        cls.is_b    = (opcode[10:5] == OP_B_PFX);
        cls.illegal = !(cls.is_r || cls.is_mem || cls.is_cb || cls.is_b);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the LEGv8 datapath over several
// cycles per instruction, with a bounded wait on the data-memory handshake,
// a retired-instruction counter and a sticky fault/halt.
//   CLK, Reset           : clock, synchronous active-high reset
//   Opcode               : IR[31:21], stable from DECODE onward
//   ALUZero, MemReady    : datapath status (MemReady only looked at in MEM)
//   IRWrite..RegWrite    : datapath mux selects and enables
//   Halted, Fault        : HALT indication and sticky fault code
//   RetireCount          : number of cycles with PCWrite=1 since reset
//   dbg_state            : current state encoding, for observation only
// Memory handshake: MemRead/MemWrite is a level request held every MEM cycle;
// the access completes in the cycle MemReady is sampled high. Nothing is
// requested outside MEM, and Reset drops the request in the same cycle.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [10:0]        Opcode,
    input  logic               ALUZero,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               Reg2Loc,
    output logic               ALUSrc,
    output logic [1:0]         ALUOp,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               Halted,
    output logic [1:0]         Fault,
    output logic [COUNT_W-1:0] RetireCount,
    output logic [3:0]         dbg_state
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [1:0]         fault_q, fault_nxt;
    logic               is_load_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [COUNT_W-1:0] retire_q;
    op_class_t          cls;

    logic       ir_w, pc_w, pc_src, r2l, alu_src, mem_rd, mem_wr, m2r, reg_w, halted;
    logic [1:0] alu_op;

    opcode_classifier u_classifier (
        .opcode (Opcode),
        .cls    (cls)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_FETCH;
            fault_q   <= FAULT_NONE;
            is_load_q <= 1'b0;
            tmo_cnt   <= '0;
            retire_q  <= '0;
        end else begin
            state   <= state_nxt;
            fault_q <= fault_nxt;
            // Remember load/store at decode so MEM does not depend on Opcode later
            if (state == ST_DECODE)
                is_load_q <= cls.is_load;
            // Held at zero outside MEM, so it is already clear on entry
            if (state == ST_MEM)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (pc_w)
                retire_q <= retire_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        fault_nxt = fault_q;
        ir_w      = 1'b0;
        pc_w      = 1'b0;
        pc_src    = 1'b0;
        r2l       = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALUOP_ADD;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        m2r       = 1'b0;
        reg_w     = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_FETCH: begin
                ir_w      = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls.is_r)        state_nxt = ST_EXEC_R;
                else if (cls.is_mem) state_nxt = ST_EXEC_M;
                else if (cls.is_cb)  state_nxt = ST_EXEC_CB;
                else if (cls.is_b)   state_nxt = ST_BR;
                else begin
                    state_nxt = ST_HALT;
                    fault_nxt = FAULT_ILLEGAL;
                end
            end
            ST_EXEC_R: begin
                alu_op    = ALUOP_RTYPE;
                state_nxt = ST_WB_R;
            end
            ST_WB_R: begin
                alu_op    = ALUOP_RTYPE;
                reg_w     = 1'b1;
                pc_w      = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_EXEC_M: begin
                r2l       = 1'b1;
                alu_src   = 1'b1;
                state_nxt = ST_MEM;
            end
            ST_MEM: begin
                r2l     = 1'b1;
                alu_src = 1'b1;
                mem_rd  = is_load_q;
                mem_wr  = !is_load_q;
                // MemReady takes priority over an expiring timeout
                if (MemReady) begin
                    if (is_load_q) begin
                        state_nxt = ST_WB_M;
                    end else begin
                        pc_w      = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_HALT;
                    fault_nxt = FAULT_MEM_TMO;
                end
            end
            ST_WB_M: begin
                alu_src   = 1'b1;
                m2r       = 1'b1;
                reg_w     = 1'b1;
                pc_w      = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_EXEC_CB: begin
                r2l       = 1'b1;
                alu_op    = ALUOP_PASS_B;
                pc_w      = 1'b1;
                pc_src    = ALUZero;
                state_nxt = ST_FETCH;
            end
            ST_BR: begin
                pc_w      = 1'b1;
                pc_src    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                // Corrupted state register: stop rather than run garbage
                state_nxt = ST_HALT;
                fault_nxt = FAULT_ILLEGAL;
            end
        endcase
    end

    // Reset overrides every output combinationally, so a pending memory
    // request is withdrawn in the reset cycle itself.
    assign IRWrite     = ir_w    & ~Reset;
    assign PCWrite     = pc_w    & ~Reset;
    assign PCSrc       = pc_src  & ~Reset;
    assign Reg2Loc     = r2l     & ~Reset;
    assign ALUSrc      = alu_src & ~Reset;
    assign ALUOp       = Reset ? 2'b00 : alu_op;
    assign MemRead     = mem_rd  & ~Reset;
    assign MemWrite    = mem_wr  & ~Reset;
    assign MemToReg    = m2r     & ~Reset;
    assign RegWrite    = reg_w   & ~Reset;
    assign Halted      = halted  & ~Reset;
    assign Fault       = Reset ? FAULT_NONE : fault_q;
    assign RetireCount = Reset ? '0 : retire_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Each cycle of stimulus is queued together
// with the control vector and state the bench expects for that cycle; each
// test task then drains the queues, comparing outputs sampled 1 ns after the
// falling edge. RetireCount is tracked by a separate counter model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [10:0] Opcode;
    logic        ALUZero, MemReady;
    logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemRead, MemWrite;
    logic        MemToReg, RegWrite, Halted;
    logic [1:0]  ALUOp, Fault;
    logic [31:0] RetireCount;
    logic [3:0]  dbg_state;

    always #5 CLK = ~CLK;

    multicycle_control #(.MEM_TIMEOUT(16), .COUNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .ALUZero(ALUZero), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .Halted(Halted), .Fault(Fault),
        .RetireCount(RetireCount), .dbg_state(dbg_state)
    );

    // Vector layout: {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, ALUOp[1:0],
    //                 MemRead, MemWrite, MemToReg, RegWrite, Halted, Fault[1:0]}
    localparam logic [13:0] V_ZERO = 14'b0_0_0_0_0_00_0_0_0_0_0_00;
    localparam logic [13:0] V_F    = 14'b1_0_0_0_0_00_0_0_0_0_0_00;
    localparam logic [13:0] V_ER   = 14'b0_0_0_0_0_10_0_0_0_0_0_00;
    localparam logic [13:0] V_WBR  = 14'b0_1_0_0_0_10_0_0_0_1_0_00;
    localparam logic [13:0] V_EM   = 14'b0_0_0_1_1_00_0_0_0_0_0_00;
    localparam logic [13:0] V_MR   = 14'b0_0_0_1_1_00_1_0_0_0_0_00;
    localparam logic [13:0] V_MW   = 14'b0_0_0_1_1_00_0_1_0_0_0_00;
    localparam logic [13:0] V_MWD  = 14'b0_1_0_1_1_00_0_1_0_0_0_00;
    localparam logic [13:0] V_WBM  = 14'b0_1_0_0_1_00_0_0_1_1_0_00;
    localparam logic [13:0] V_CB0  = 14'b0_1_0_1_0_01_0_0_0_0_0_00;
    localparam logic [13:0] V_CB1  = 14'b0_1_1_1_0_01_0_0_0_0_0_00;
    localparam logic [13:0] V_BR   = 14'b0_1_1_0_0_00_0_0_0_0_0_00;
    localparam logic [13:0] V_H1   = 14'b0_0_0_0_0_00_0_0_0_0_1_01;
    localparam logic [13:0] V_H2   = 14'b0_0_0_0_0_00_0_0_0_0_1_10;

    int          nerr = 0;
    int          nchk = 0;
    logic [31:0] exp_retire;
    logic [17:0] exp_q[$];   // {state, vector}
    logic [13:0] stim_q[$];  // {reset, mem_ready, alu_zero, opcode}

    // ---------------- driver tasks ----------------
    task automatic push(input logic rst, input logic mr, input logic az,
                        input logic [10:0] op, input state_t st, input logic [13:0] v);
        stim_q.push_back({rst, mr, az, op});
        exp_q.push_back({4'(st), v});
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one legal instruction.
    // w = cycles MemReady stays low in MEM; az = ALUZero in EXEC_CB.
    task automatic push_instr(input logic [10:0] op, input int w, input logic az);
        push(0, rnd_bit(), rnd_bit(), op, ST_FETCH, V_F);
        push(0, rnd_bit(), rnd_bit(), op, ST_DECODE, V_ZERO);
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
            push(0, rnd_bit(), rnd_bit(), op, ST_EXEC_R, V_ER);
            push(0, rnd_bit(), rnd_bit(), op, ST_WB_R, V_WBR);
        end else if (op == 11'h7C2) begin
            push(0, rnd_bit(), rnd_bit(), op, ST_EXEC_M, V_EM);
            for (int i = 0; i < w; i++) push(0, 0, rnd_bit(), op, ST_MEM, V_MR);
            push(0, 1, rnd_bit(), op, ST_MEM, V_MR);
            push(0, rnd_bit(), rnd_bit(), op, ST_WB_M, V_WBM);
        end else if (op == 11'h7C0) begin
            push(0, rnd_bit(), rnd_bit(), op, ST_EXEC_M, V_EM);
            for (int i = 0; i < w; i++) push(0, 0, rnd_bit(), op, ST_MEM, V_MW);
            push(0, 1, rnd_bit(), op, ST_MEM, V_MWD);
        end else if (op >= 11'h5A0 && op <= 11'h5A7) begin
            push(0, rnd_bit(), az, op, ST_EXEC_CB, az ? V_CB1 : V_CB0);
        end else begin
            push(0, rnd_bit(), rnd_bit(), op, ST_BR, V_BR);
        end
    endtask

    task automatic step(input logic [13:0] s, output logic [17:0] o, output logic [31:0] rc);
        @(negedge CLK);
        Reset    = s[13];
        MemReady = s[12];
        ALUZero  = s[11];
        Opcode   = s[10:0];
        #1;
        o  = {dbg_state, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, ALUOp,
              MemRead, MemWrite, MemToReg, RegWrite, Halted, Fault};
        rc = RetireCount;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push(1, 1, 1, 11'h458, ST_FETCH, V_ZERO);
        push(1, 0, 1, 11'h7C2, ST_FETCH, V_ZERO);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL reset ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== 32'd0) begin nerr++; $display("FAIL reset retire: got %0d want 0", rc); end
        end
        exp_retire = 0;
    endtask

    task automatic test_add();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push_instr(11'h458, 0, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL add ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL add retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
    endtask

    task automatic test_ldur();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc; int rd_cycles, cycles;
        rd_cycles = 0; cycles = 0;
        push_instr(11'h7C2, 3, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            cycles++; if (o[6]) rd_cycles++;
            nchk++; if (o !== e) begin nerr++; $display("FAIL ldur ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL ldur retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
        nchk++; if (rd_cycles != 4) begin nerr++; $display("FAIL ldur memread_cycles: got %0d want 4", rd_cycles); end
        nchk++; if (cycles != 8) begin nerr++; $display("FAIL ldur latency: got %0d want 8", cycles); end
    endtask

    task automatic test_stur();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push_instr(11'h7C0, 0, 0);
        push_instr(11'h7C0, $urandom_range(1, 6), 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL stur ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL stur retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
    endtask

    task automatic test_cbz();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push_instr(11'h5A4, 0, 1);
        push_instr(11'h5A0 + 11'($urandom_range(0, 7)), 0, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL cbz ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL cbz retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
    endtask

    task automatic test_branch();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push_instr(11'h0A0, 0, 0);
        push_instr(11'h0BF, 0, 0);
        push_instr(11'h0A0 + 11'($urandom_range(0, 31)), 0, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL branch ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL branch retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        logic [10:0] ops[8];
        ops = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h7C2, 11'h7C0, 11'h5A3, 11'h0B5};
        for (int i = 0; i < 10; i++)
            push_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), rnd_bit());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL b2b ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL b2b retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
    endtask

    // MemReady arriving in the last allowed MEM cycle completes the store.
    task automatic test_timeout_edge();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push_instr(11'h7C0, 15, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL tmo_edge ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== exp_retire) begin nerr++; $display("FAIL tmo_edge retire: got %0d want %0d", rc, exp_retire); end
            if (e[12]) exp_retire++;
        end
    endtask

    task automatic test_timeout();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push(0, 0, 0, 11'h7C0, ST_FETCH, V_F);
        push(0, 0, 0, 11'h7C0, ST_DECODE, V_ZERO);
        push(0, 0, 0, 11'h7C0, ST_EXEC_M, V_EM);
        for (int i = 0; i < 16; i++) push(0, 0, rnd_bit(), 11'h7C0, ST_MEM, V_MW);
        for (int i = 0; i < 4; i++) push(0, rnd_bit(), rnd_bit(), 11'h7C0, ST_HALT, V_H2);
        push(1, 0, 0, 11'h7C0, ST_HALT, V_ZERO);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL timeout ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== (s[13] ? 32'd0 : exp_retire)) begin nerr++; $display("FAIL timeout retire: got %0d want %0d", rc, exp_retire); end
            if (s[13]) exp_retire = 0; else if (e[12]) exp_retire++;
        end
    endtask

    task automatic test_illegal();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push(0, 0, 0, 11'h7FF, ST_FETCH, V_F);
        push(0, 0, 0, 11'h7FF, ST_DECODE, V_ZERO);
        for (int i = 0; i < 3; i++) push(0, rnd_bit(), rnd_bit(), 11'h7FF, ST_HALT, V_H1);
        push(1, 0, 0, 11'h7FF, ST_HALT, V_ZERO);
        push_instr(11'h550, 0, 0);
        push(0, 0, 0, 11'h459, ST_FETCH, V_F);
        push(0, 0, 0, 11'h459, ST_DECODE, V_ZERO);
        push(0, 1, 1, 11'h459, ST_HALT, V_H1);
        push(1, 0, 0, 11'h459, ST_HALT, V_ZERO);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL illegal ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== (s[13] ? 32'd0 : exp_retire)) begin nerr++; $display("FAIL illegal retire: got %0d want %0d", rc, exp_retire); end
            if (s[13]) exp_retire = 0; else if (e[12]) exp_retire++;
        end
    endtask

    // Reset in MEM with MemReady high: request dropped, no writeback, FETCH next.
    task automatic test_reset_in_mem();
        logic [13:0] s; logic [17:0] e, o; logic [31:0] rc;
        push_instr(11'h458, 0, 0);
        push(0, 0, 0, 11'h7C2, ST_FETCH, V_F);
        push(0, 0, 0, 11'h7C2, ST_DECODE, V_ZERO);
        push(0, 0, 0, 11'h7C2, ST_EXEC_M, V_EM);
        push(0, 0, 0, 11'h7C2, ST_MEM, V_MR);
        push(1, 1, 0, 11'h7C2, ST_MEM, V_ZERO);
        push(0, 1, 0, 11'h7C2, ST_FETCH, V_F);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); step(s, o, rc);
            nchk++; if (o !== e) begin nerr++; $display("FAIL rst_mem ctrl: got %h want %h", o, e); end
            nchk++; if (rc !== (s[13] ? 32'd0 : exp_retire)) begin nerr++; $display("FAIL rst_mem retire: got %0d want %0d", rc, exp_retire); end
            if (s[13]) exp_retire = 0; else if (e[12]) exp_retire++;
        end
    endtask

    initial begin
        Reset      = 1'b1;
        MemReady   = 1'b0;
        ALUZero    = 1'b0;
        Opcode     = 11'h0;
        exp_retire = 0;
        repeat (2) @(posedge CLK);
        test_reset();
        test_add();
        test_ldur();
        test_stur();
        test_cbz();
        test_branch();
        test_back_to_back();
        test_timeout_edge();
        test_timeout();
        test_illegal();
        test_reset_in_mem();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // Absolute bound on run time in case the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
